// File: rtl/ddr_rx_word_deser.sv
// ddr_rx_word_deser
//   HDR-DDR receive deserializer. Samples SDA on both SCL edges and captures
//   preamble bits, data words with two parity bits, and CRC words
//   (token + CRC field). Checks parity, token and, optionally, the CRC.
//
//   Build option: define RX_CRC_CHECK_EN to include the internal CRC5
//   accumulator (x^5+x^2+1, init 5'h1F, MSB first) and compare it against
//   the CRC field of each CRC word. Without it the CRC field is ignored.
//
// Ports
//   i_sys_clk        system clock
//   i_sys_rst        synchronous active-high reset
//   i_scl_pos_edge   1-cycle strobe, SCL rising edge
//   i_scl_neg_edge   1-cycle strobe, SCL falling edge
//   i_rx_en          block enable
//   i_rx_sda         sampled SDA
//   i_rx_mode        000 PRE1, 001 PRE2, 011 WORD, 101 CRCW; others illegal
//   i_rx_err_clr     clears the sticky error
//   o_rx_data        last accepted data word
//   o_rx_data_valid  1-cycle pulse, word passed parity
//   o_rx_pre         captured preamble bits {p1,p0}; PRE1 uses bit 0
//   o_rx_mode_done   1-cycle pulse, current mode complete
//   o_rx_error       sticky error flag
//   o_rx_err_code    0 illegal mode, 1 parity, 2 token, 3 CRC
//   o_crc_en         pulses with o_rx_data_valid for an external CRC
module ddr_rx_word_deser #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned CRC_W  = 5,
  parameter logic [3:0]  TOKEN  = 4'hC
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_scl_pos_edge,
  input  logic              i_scl_neg_edge,
  input  logic              i_rx_en,
  input  logic              i_rx_sda,
  input  logic [2:0]        i_rx_mode,
  input  logic              i_rx_err_clr,
  output logic [WORD_W-1:0] o_rx_data,
  output logic              o_rx_data_valid,
  output logic [1:0]        o_rx_pre,
  output logic              o_rx_mode_done,
  output logic              o_rx_error,
  output logic [1:0]        o_rx_err_code,
  output logic              o_crc_en
);

  localparam int unsigned WORD_BITS = WORD_W + 2;
  localparam int unsigned CRCW_BITS = 4 + CRC_W;
  localparam int unsigned SR_W      = (WORD_BITS > CRCW_BITS) ? WORD_BITS : CRCW_BITS;
  localparam int unsigned CNT_W     = $clog2(SR_W + 1);

  localparam logic [2:0] MODE_PRE1 = 3'b000;
  localparam logic [2:0] MODE_PRE2 = 3'b001;
  localparam logic [2:0] MODE_WORD = 3'b011;
  localparam logic [2:0] MODE_CRCW = 3'b101;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  localparam logic [1:0] ERR_MODE   = 2'd0;
  localparam logic [1:0] ERR_PARITY = 2'd1;
  localparam logic [1:0] ERR_TOKEN  = 2'd2;
  localparam logic [1:0] ERR_CRC    = 2'd3;

  function automatic logic [WORD_W-1:0] gen_odd_mask();
    logic [WORD_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < WORD_W; i++) m[i] = i[0];
    return m;
  endfunction

  localparam logic [WORD_W-1:0] ODD_MASK = gen_odd_mask();

  function automatic logic is_legal(input logic [2:0] m);
    return (m == MODE_PRE1) || (m == MODE_PRE2) || (m == MODE_WORD) || (m == MODE_CRCW);
  endfunction

  logic [1:0]        state;
  logic [2:0]        mode_q;
  logic [CNT_W-1:0]  cnt;
  logic [SR_W-2:0]   sr;
  logic [CNT_W-1:0]  nbits;
  logic [SR_W-1:0]   full;
  logic              samp;
  logic              last;
  logic              abort;
  logic              mode_legal;
  logic [WORD_W-1:0] word_data;
  logic              parity_ok;
  logic [3:0]        token_rx;
  logic              err_set;
  logic [1:0]        err_new;

`ifdef RX_CRC_CHECK_EN
  logic [4:0]        crc_acc;
  logic [CRC_W-1:0]  crc_rx;

  function automatic logic [4:0] crc5_next(input logic [4:0] acc, input logic [WORD_W-1:0] d);
    logic [4:0] c;
    logic       fb;
    c = acc;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      fb = c[4] ^ d[WORD_W-1-i];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    return c;
  endfunction

  assign crc_rx = full[CRC_W-1:0];
`endif

  assign samp       = i_scl_pos_edge | i_scl_neg_edge;
  assign mode_legal = is_legal(i_rx_mode);
  // Register contents including the bit being sampled this cycle.
  assign full       = {sr, i_rx_sda};
  assign word_data  = full[WORD_W+1:2];
  assign parity_ok  = (full[1] == ^(word_data & ODD_MASK)) &&
                      (full[0] == ~(^(word_data & ~ODD_MASK)));
  assign token_rx   = full[CRC_W+3:CRC_W];
  assign abort      = (state == ST_SHIFT) && (!i_rx_en || (i_rx_mode != mode_q));
  assign last       = samp && (cnt == nbits - CNT_W'(1));

  always_comb begin
    nbits = CNT_W'(1);
    case (mode_q)
      MODE_PRE1: nbits = CNT_W'(1);
      MODE_PRE2: nbits = CNT_W'(2);
      MODE_WORD: nbits = CNT_W'(WORD_BITS);
      MODE_CRCW: nbits = CNT_W'(CRCW_BITS);
      default:   nbits = CNT_W'(1);
    endcase
  end

  always_comb begin
    err_set = 1'b0;
    err_new = ERR_MODE;
    if (state == ST_IDLE) begin
      if (i_rx_en && !mode_legal) err_set = 1'b1;
    end else if ((state == ST_SHIFT) && !abort && last) begin
      if ((mode_q == MODE_WORD) && !parity_ok) begin
        err_set = 1'b1;
        err_new = ERR_PARITY;
      end else if (mode_q == MODE_CRCW) begin
        if (token_rx != TOKEN) begin
          err_set = 1'b1;
          err_new = ERR_TOKEN;
        end
`ifdef RX_CRC_CHECK_EN
        else if (crc_rx != CRC_W'(crc_acc)) begin
          err_set = 1'b1;
          err_new = ERR_CRC;
        end
`endif
      end
    end
  end

  // The result is evaluated on the edge that samples the last bit so that
  // data, valid and done are all visible during the single CHECK cycle.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state           <= ST_IDLE;
      mode_q          <= MODE_PRE1;
      cnt             <= '0;
      sr              <= '0;
      o_rx_data       <= '0;
      o_rx_data_valid <= 1'b0;
      o_rx_pre        <= '0;
      o_rx_mode_done  <= 1'b0;
      o_rx_error      <= 1'b0;
      o_rx_err_code   <= '0;
      o_crc_en        <= 1'b0;
`ifdef RX_CRC_CHECK_EN
      crc_acc         <= 5'h1F;
`endif
    end else begin
      o_rx_data_valid <= 1'b0;
      o_rx_mode_done  <= 1'b0;
      o_crc_en        <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (i_rx_en && mode_legal) begin
            state  <= ST_SHIFT;
            mode_q <= i_rx_mode;
            cnt    <= '0;
            sr     <= '0;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (samp) begin
            sr  <= full[SR_W-2:0];
            cnt <= cnt + CNT_W'(1);
            if (last) begin
              state          <= ST_CHECK;
              o_rx_mode_done <= 1'b1;
              case (mode_q)
                MODE_PRE1: o_rx_pre <= {1'b0, full[0]};
                MODE_PRE2: o_rx_pre <= full[1:0];
                MODE_WORD: begin
                  if (parity_ok) begin
                    o_rx_data       <= word_data;
                    o_rx_data_valid <= 1'b1;
                    o_crc_en        <= 1'b1;
`ifdef RX_CRC_CHECK_EN
                    crc_acc         <= crc5_next(crc_acc, word_data);
`endif
                  end
                end
                MODE_CRCW: begin
`ifdef RX_CRC_CHECK_EN
                  crc_acc <= 5'h1F;
`endif
                end
                default: ;
              endcase
            end
          end
        end
        ST_CHECK: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase

      // First error wins; a clear in the same cycle as a new error lets the
      // new code through.
      if (err_set) begin
        o_rx_error <= 1'b1;
        if (!o_rx_error || i_rx_err_clr) o_rx_err_code <= err_new;
      end else if (i_rx_err_clr) begin
        o_rx_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ddr_rx_word_deser.sv
// tb_ddr_rx_word_deser
//   Scoreboard bench for ddr_rx_word_deser (WORD_W=16, CRC_W=5, TOKEN=4'hC).
//   Expected completions are queued as stimulus is driven and compared when
//   o_rx_mode_done pulses. Honours RX_CRC_CHECK_EN in its expectations.
module tb_ddr_rx_word_deser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pos = 1'b0;
  logic        neg = 1'b0;
  logic        en  = 1'b0;
  logic        sda = 1'b0;
  logic [2:0]  mode = 3'b000;
  logic        clr = 1'b0;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic [1:0]  rx_pre;
  logic        done;
  logic        rx_error;
  logic [1:0]  err_code;
  logic        crc_en;

  ddr_rx_word_deser #(.WORD_W(16), .CRC_W(5), .TOKEN(4'hC)) dut (
    .i_sys_clk      (clk),
    .i_sys_rst      (rst),
    .i_scl_pos_edge (pos),
    .i_scl_neg_edge (neg),
    .i_rx_en        (en),
    .i_rx_sda       (sda),
    .i_rx_mode      (mode),
    .i_rx_err_clr   (clr),
    .o_rx_data      (rx_data),
    .o_rx_data_valid(rx_valid),
    .o_rx_pre       (rx_pre),
    .o_rx_mode_done (done),
    .o_rx_error     (rx_error),
    .o_rx_err_code  (err_code),
    .o_crc_en       (crc_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        valid;
    logic        err;
    logic [1:0]  code;
    logic [1:0]  pre;
    logic [1:0]  pre_mask;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic [15:0] m_data = '0;
  logic [1:0]  m_pre  = '0;
  logic        m_err  = 1'b0;
  logic [1:0]  m_code = '0;
  logic [4:0]  m_acc  = 5'h1F;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] word_bits(input logic [15:0] d, input logic flip);
    logic pa1, pa0;
    pa1 = ^(d & 16'hAAAA);
    pa0 = ~(^(d & 16'h5555));
    return {d, pa1, pa0 ^ flip};
  endfunction

  function automatic logic [4:0] crc5_ref(input logic [4:0] acc, input logic [15:0] d);
    logic [4:0] c;
    c = acc;
    for (int i = 15; i >= 0; i--) begin
      if (c[4] ^ d[i]) c = {c[3:0], 1'b0} ^ 5'h05;
      else             c = {c[3:0], 1'b0};
    end
    return c;
  endfunction

  task automatic model_err(input logic [1:0] code);
    if (!m_err) m_code = code;
    m_err = 1'b1;
  endtask

  task automatic push_exp(input logic valid, input logic [1:0] pmask);
    exp_t e;
    e.data = m_data; e.valid = valid; e.err = m_err; e.code = m_code;
    e.pre = m_pre; e.pre_mask = pmask;
    sb.push_back(e);
  endtask

  task automatic start(input logic [2:0] md);
    @(negedge clk);
    mode = md;
    en   = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input int nsend);
    for (int i = 0; i < nsend; i++) begin
      @(negedge clk);
      sda = bits[n-1-i];
      if (i % 2 == 0) pos = 1'b1;
      else            neg = 1'b1;
      @(negedge clk);
      pos = 1'b0;
      neg = 1'b0;
    end
  endtask

  task automatic finish_xfer();
    check_eq("done_latency", {31'd0, done}, 32'd1);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_pre1(input logic b);
    m_pre = {1'b0, b};
    push_exp(1'b0, 2'b01);
    start(3'b000);
    send_bits({31'd0, b}, 1, 1);
    finish_xfer();
  endtask

  task automatic do_pre2(input logic b1, input logic b0);
    m_pre = {b1, b0};
    push_exp(1'b0, 2'b11);
    start(3'b001);
    send_bits({30'd0, b1, b0}, 2, 2);
    finish_xfer();
  endtask

  task automatic do_word(input logic [15:0] d, input logic flip);
    if (!flip) begin
      m_data = d;
      m_acc  = crc5_ref(m_acc, d);
    end else begin
      model_err(2'd1);
    end
    push_exp(!flip, 2'b11);
    start(3'b011);
    send_bits({14'd0, word_bits(d, flip)}, 18, 18);
    finish_xfer();
  endtask

  task automatic do_crcw(input logic [3:0] tok, input logic [4:0] crc);
    if (tok != 4'hC) model_err(2'd2);
`ifdef RX_CRC_CHECK_EN
    else if (crc != m_acc) model_err(2'd3);
`endif
    m_acc = 5'h1F;
    push_exp(1'b0, 2'b11);
    start(3'b101);
    send_bits({23'd0, tok, crc}, 9, 9);
    finish_xfer();
  endtask

  task automatic clear_err();
    @(negedge clk);
    clr = 1'b1;
    m_err = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    check_eq("err_clear", {31'd0, rx_error}, 32'd0);
  endtask

  // Completion monitor: samples one time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (done) begin
          if (sb.size() == 0) begin
            check_eq("spurious_done", {31'd0, done}, 32'd0);
          end else begin
            e = sb.pop_front();
            check_eq("data", {16'd0, rx_data}, {16'd0, e.data});
            check_eq("valid", {31'd0, rx_valid}, {31'd0, e.valid});
            check_eq("crc_en", {31'd0, crc_en}, {31'd0, e.valid});
            check_eq("error", {31'd0, rx_error}, {31'd0, e.err});
            if (e.err) check_eq("err_code", {30'd0, err_code}, {30'd0, e.code});
            check_eq("pre", {30'd0, rx_pre & e.pre_mask}, {30'd0, e.pre & e.pre_mask});
          end
        end else if (rx_valid || crc_en) begin
          check_eq("pulse_without_done", {30'd0, rx_valid, crc_en}, 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_data", {16'd0, rx_data}, 32'd0);
    check_eq("rst_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("rst_pre", {30'd0, rx_pre}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_error", {31'd0, rx_error}, 32'd0);
    check_eq("rst_code", {30'd0, err_code}, 32'd0);
    check_eq("rst_crc_en", {31'd0, crc_en}, 32'd0);

    do_pre2(1'b1, 1'b0);
    do_pre1(1'b1);
    do_word(16'hA5C3, 1'b0);
    do_crcw(4'hC, m_acc);          // correct CRC in either build
    do_word(16'h1234, 1'b0);
    do_word(16'hA5C3, 1'b1);       // PA0 flipped: parity error, data holds
    do_crcw(4'hA, 5'h00);          // token error, first code (parity) kept
    clear_err();
    do_crcw(4'hA, m_acc);          // token error, code 2
    clear_err();
    do_word(16'h0001, 1'b0);       // boundary: single set even-index bit
    do_word(16'hFFFF, 1'b0);
    do_crcw(4'hC, m_acc);
    do_word(16'hA5C3, 1'b0);
    do_crcw(4'hC, m_acc ^ 5'h01);  // CRC flipped: code 3 only with CRC check
    clear_err();

    // Mode change mid-word: no completion, then a clean PRE2.
    start(3'b011);
    send_bits({14'd0, word_bits(16'h5A5A, 1'b0)}, 18, 7);
    do_pre2(1'b0, 1'b1);
    check_eq("abort_mode_data", {16'd0, rx_data}, {16'd0, m_data});

    // Enable dropped mid-word: outputs hold.
    start(3'b011);
    send_bits({14'd0, word_bits(16'h0F0F, 1'b0)}, 18, 5);
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("abort_en_data", {16'd0, rx_data}, {16'd0, m_data});
    check_eq("abort_en_error", {31'd0, rx_error}, {31'd0, m_err});
    do_pre1(1'b0);

    // Illegal mode together with a clear of an existing token error.
    do_crcw(4'h3, m_acc);
    @(negedge clk);
    mode = 3'b111;
    en   = 1'b1;
    clr  = 1'b1;
    m_err = 1'b0;
    model_err(2'd0);
    @(negedge clk);
    clr = 1'b0;
    en  = 1'b0;
    check_eq("illegal_error", {31'd0, rx_error}, {31'd0, m_err});
    check_eq("illegal_code", {30'd0, err_code}, {30'd0, m_code});
    clear_err();

    // Reset mid-word discards the partial word.
    start(3'b011);
    send_bits({14'd0, word_bits(16'hBEEF, 1'b0)}, 18, 6);
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_data = '0; m_pre = '0; m_err = 1'b0; m_code = '0; m_acc = 5'h1F;
    check_eq("midword_rst_data", {16'd0, rx_data}, 32'd0);
    do_word(16'hA5C3, 1'b0);
    do_crcw(4'hC, m_acc);

    repeat (4) @(negedge clk);
    check_eq("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
